// File: rtl/can_bridge_pkg.sv
// Shared types and constants for the guarded wired-AND CAN bridge.
// No storage or flow control; the bus levels are active-low (0 = dominant).
package can_bridge_pkg;

  typedef enum logic {
    ST_ACTIVE   = 1'b0,
    ST_ISOLATED = 1'b1
  } node_state_e;

  localparam logic CAN_DOMINANT  = 1'b0;
  localparam logic CAN_RECESSIVE = 1'b1;

  // Width that holds the larger of the two run-length limits without wrapping.
  function automatic int cnt_width(input int dom_limit, input int rec_limit);
    int m;
    m = (dom_limit > rec_limit) ? dom_limit : rec_limit;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/can_node_guard.sv
// Per-node synchroniser, babble detector and isolation FSM; gated TX feeds the bus AND.
// Latency: can_tx reaches gated after 2 edges; no backpressure (always accepts samples).
module can_node_guard
  import can_bridge_pkg::*;
#(
  parameter int DOM_LIMIT = 1000,
  parameter int REC_LIMIT = 600,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             can_tx,
  input  logic             node_en,
  input  logic             bus_rx,
  output logic             gated,
  output logic             isolated,
  output logic             fault_pulse,
  output logic [CNT_W-1:0] fault_cnt
);

  localparam int            CW       = cnt_width(DOM_LIMIT, REC_LIMIT);
  localparam logic [CW-1:0] DOM_LAST = CW'(DOM_LIMIT - 1);
  localparam logic [CW-1:0] REC_MAX  = CW'(REC_LIMIT);

  logic             sync1_q, sync2_q;
  logic             tx_s;
  node_state_e      state_q, state_d;
  logic [CW-1:0]    dom_cnt_q, dom_cnt_d;
  logic [CW-1:0]    rec_cnt_q, rec_cnt_d;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic             fault_pulse_q, fault_pulse_d;

  assign tx_s = sync2_q;

  always_comb begin
    state_d       = state_q;
    dom_cnt_d     = dom_cnt_q;
    rec_cnt_d     = rec_cnt_q;
    fault_cnt_d   = fault_cnt_q;
    fault_pulse_d = 1'b0;
    if (!node_en) begin
      state_d   = ST_ACTIVE;
      dom_cnt_d = '0;
      rec_cnt_d = '0;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          rec_cnt_d = '0;
          if (tx_s == CAN_DOMINANT) begin
            if (dom_cnt_q == DOM_LAST) begin
              state_d       = ST_ISOLATED;
              dom_cnt_d     = '0;
              fault_pulse_d = 1'b1;
              if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + 1'b1;
            end else begin
              dom_cnt_d = dom_cnt_q + 1'b1;
            end
          end else begin
            dom_cnt_d = '0;
          end
        end
        ST_ISOLATED: begin
          dom_cnt_d = '0;
          // Re-admission waits for an idle bus so the node never rejoins mid-frame.
          if (rec_cnt_q == REC_MAX && bus_rx == CAN_RECESSIVE) begin
            state_d   = ST_ACTIVE;
            rec_cnt_d = '0;
          end else if (tx_s == CAN_RECESSIVE) begin
            if (rec_cnt_q != REC_MAX) rec_cnt_d = rec_cnt_q + 1'b1;
          end else begin
            rec_cnt_d = '0;
          end
        end
        default: state_d = ST_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= CAN_RECESSIVE;
      sync2_q       <= CAN_RECESSIVE;
      state_q       <= ST_ACTIVE;
      dom_cnt_q     <= '0;
      rec_cnt_q     <= '0;
      fault_cnt_q   <= '0;
      fault_pulse_q <= 1'b0;
    end else begin
      sync1_q       <= can_tx;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      dom_cnt_q     <= dom_cnt_d;
      rec_cnt_q     <= rec_cnt_d;
      fault_cnt_q   <= fault_cnt_d;
      fault_pulse_q <= fault_pulse_d;
    end
  end

  assign gated       = tx_s | ~node_en | (state_q == ST_ISOLATED);
  assign isolated    = (state_q == ST_ISOLATED);
  assign fault_pulse = fault_pulse_q;
  assign fault_cnt   = fault_cnt_q;

endmodule

// File: rtl/can_bus_guard.sv
// Guarded wired-AND bridge for N CAN controllers with babbling-node isolation.
// Latency: can_tx to can_rx is 3 clk edges; no backpressure (bus level is broadcast every cycle).
module can_bus_guard
  import can_bridge_pkg::*;
#(
  parameter int N_NODES   = 4,
  parameter int DOM_LIMIT = 1000,
  parameter int REC_LIMIT = 600,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_NODES-1:0]       can_tx,
  output logic [N_NODES-1:0]       can_rx,
  input  logic [N_NODES-1:0]       node_en,
  output logic [N_NODES-1:0]       isolated,
  output logic [N_NODES-1:0]       fault_pulse,
  output logic [N_NODES*CNT_W-1:0] fault_cnt
);

  logic [N_NODES-1:0] gated;
  logic [N_NODES-1:0] can_rx_q, can_rx_d;

  for (genvar i = 0; i < N_NODES; i++) begin : g_node
    can_node_guard #(
      .DOM_LIMIT (DOM_LIMIT),
      .REC_LIMIT (REC_LIMIT),
      .CNT_W     (CNT_W)
    ) u_node (
      .clk         (clk),
      .rst         (rst),
      .can_tx      (can_tx[i]),
      .node_en     (node_en[i]),
      .bus_rx      (can_rx_q[i]),
      .gated       (gated[i]),
      .isolated    (isolated[i]),
      .fault_pulse (fault_pulse[i]),
      .fault_cnt   (fault_cnt[i*CNT_W +: CNT_W])
    );
  end

  always_comb begin
    can_rx_d = {N_NODES{&gated}};
  end

  always_ff @(posedge clk) begin
    if (rst) can_rx_q <= {N_NODES{CAN_RECESSIVE}};
    else     can_rx_q <= can_rx_d;
  end

  assign can_rx = can_rx_q;

endmodule

// File: tb/tb_can_bus_guard.sv
// Bench for can_bus_guard: directed scenarios plus random traffic against a run-length reference model.
module tb_can_bus_guard;

  localparam int N  = 4;
  localparam int DL = 8;
  localparam int RL = 16;
  localparam int CW = 8;
  localparam int VW = 3*N + N*CW;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  can_tx, can_rx, node_en, isolated, fault_pulse;
  logic [N*CW-1:0] fault_cnt;
  logic [VW-1:0] dut_vec;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  can_bus_guard #(.N_NODES(N), .DOM_LIMIT(DL), .REC_LIMIT(RL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .can_tx(can_tx), .can_rx(can_rx), .node_en(node_en),
    .isolated(isolated), .fault_pulse(fault_pulse), .fault_cnt(fault_cnt)
  );

  assign dut_vec = {can_rx, isolated, fault_pulse, fault_cnt};

  // Reference: raw TX seen two samples late, then run lengths of dominant/recessive samples.
  logic [N-1:0] hist0, hist1, m_rx, m_iso, m_pulse, ts, gm, old_rx;
  int m_run[N], m_rrun[N], m_fc[N];

  always @(posedge clk) begin
    if (rst) begin
      hist0 = '1; hist1 = '1; m_rx = '1; m_iso = '0; m_pulse = '0;
      for (int i = 0; i < N; i++) begin m_run[i] = 0; m_rrun[i] = 0; m_fc[i] = 0; end
    end else begin
      ts = hist1;
      old_rx = m_rx;
      gm = ts | ~node_en | m_iso;
      m_rx = (gm == '1) ? '1 : '0;
      for (int i = 0; i < N; i++) begin
        m_pulse[i] = 1'b0;
        if (!node_en[i]) begin
          m_iso[i] = 1'b0; m_run[i] = 0; m_rrun[i] = 0;
        end else if (!m_iso[i]) begin
          m_rrun[i] = 0;
          if (!ts[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DL) begin
              m_iso[i] = 1'b1; m_run[i] = 0; m_pulse[i] = 1'b1;
              if (m_fc[i] < 255) m_fc[i] = m_fc[i] + 1;
            end
          end else m_run[i] = 0;
        end else begin
          if (m_rrun[i] == RL && old_rx[i]) begin
            m_iso[i] = 1'b0; m_rrun[i] = 0;
          end else if (ts[i]) m_rrun[i] = (m_rrun[i] < RL) ? m_rrun[i] + 1 : RL;
          else m_rrun[i] = 0;
        end
      end
      hist1 = hist0;
      hist0 = can_tx;
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    logic [N*CW-1:0] fc;
    for (int i = 0; i < N; i++) fc[i*CW +: CW] = CW'(m_fc[i]);
    return {m_rx, m_iso, m_pulse, fc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; can_tx = '1; node_en = '1;
    tick(); tick();
    n_tests++;
    if ({can_rx, isolated, fault_pulse} !== 12'hF00) begin
      n_fail++; $display("FAIL reset_flags: got %h want f00", {can_rx, isolated, fault_pulse});
    end
    n_tests++;
    if (fault_cnt !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %h want 0", fault_cnt);
    end
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec());
    end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_latency();
    logic [N-1:0] want;
    can_tx[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      want = (k >= 3 && k <= 5) ? 4'h0 : 4'hF;
      n_tests++;
      if (can_rx !== want || fault_pulse !== 4'h0) begin
        n_fail++; $display("FAIL latency k=%0d: got rx %h pulse %h want rx %h pulse 0", k, can_rx, fault_pulse, want);
      end
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL latency_model k=%0d: got %h want %h", k, dut_vec, exp_vec());
      end
      if (k == 3) can_tx[0] = 1'b1;
    end
  endtask

  task automatic test_babble();
    int first = -1;
    can_tx[2] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL babble_model k=%0d: got %h want %h", k, dut_vec, exp_vec());
      end
      if (first > 0 && k == first + 1) begin
        n_tests++;
        if (fault_pulse[2] !== 1'b0) begin
          n_fail++; $display("FAIL babble_pulse_width: got %b want 0", fault_pulse[2]);
        end
      end
      if (first > 0 && k == first + 2) begin
        n_tests++;
        if (can_rx !== 4'hF) begin
          n_fail++; $display("FAIL babble_bus_release: got %h want f", can_rx);
        end
      end
      if (fault_pulse[2] === 1'b1 && first < 0) first = k;
    end
    n_tests++;
    if (first != 10) begin
      n_fail++; $display("FAIL babble_pulse_cycle: got %0d want 10", first);
    end
    n_tests++;
    if (isolated[2] !== 1'b1 || fault_cnt[2*CW +: CW] !== 8'd1) begin
      n_fail++; $display("FAIL babble_state: got iso %b cnt %0d want iso 1 cnt 1", isolated[2], fault_cnt[2*CW +: CW]);
    end
  endtask

  task automatic test_recovery_wait();
    int k_rx = -1, k_iso = -1;
    can_tx[2] = 1'b1;
    // Nodes 0 and 1 take turns so the bus stays dominant without either one babbling.
    for (int c = 0; c < 30; c++) begin
      can_tx[1] = !((c % 8) < 6);
      can_tx[0] = !(((c + 4) % 8) < 6);
      tick();
      n_tests++;
      if (isolated[2] !== 1'b1 || dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL recovery_hold c=%0d: got %h want %h", c, dut_vec, exp_vec());
      end
    end
    can_tx = '1;
    for (int k = 1; k <= 20 && k_iso < 0; k++) begin
      tick();
      if (can_rx === 4'hF && k_rx < 0) k_rx = k;
      if (isolated[2] === 1'b0 && k_iso < 0) k_iso = k;
    end
    n_tests++;
    if (k_rx < 0 || k_iso != k_rx + 1) begin
      n_fail++; $display("FAIL recovery_timing: got iso-drop %0d want %0d", k_iso, k_rx + 1);
    end
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL recovery_model: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_simultaneous();
    int f0 = -1, f3 = -1;
    can_tx = 4'b0110;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (fault_pulse[0] === 1'b1 && f0 < 0) f0 = k;
      if (fault_pulse[3] === 1'b1 && f3 < 0) f3 = k;
    end
    n_tests++;
    if (f0 != 10 || f3 != 10) begin
      n_fail++; $display("FAIL simul_pulse: got %0d/%0d want 10/10", f0, f3);
    end
    n_tests++;
    if (isolated !== 4'b1001 || fault_cnt[0 +: CW] !== 8'd1 || fault_cnt[3*CW +: CW] !== 8'd1) begin
      n_fail++; $display("FAIL simul_state: got iso %b cnt %h want iso 1001", isolated, fault_cnt);
    end
    can_tx = '1;
    repeat (25) tick();
    n_tests++;
    if (isolated !== 4'b0000 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL simul_recover: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_disable();
    int first = -1;
    node_en[1] = 1'b0;
    can_tx[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_tests++;
      if ({can_rx, isolated, fault_pulse} !== 12'hF00) begin
        n_fail++; $display("FAIL disable_quiet k=%0d: got %h want f00", k, {can_rx, isolated, fault_pulse});
      end
    end
    node_en[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (fault_pulse[1] === 1'b1 && first < 0) first = k;
    end
    n_tests++;
    if (first != 8 || isolated[1] !== 1'b1) begin
      n_fail++; $display("FAIL disable_reenable: got pulse at %0d iso %b want 8 iso 1", first, isolated[1]);
    end
    can_tx[1] = 1'b1;
    repeat (25) tick();
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL disable_model: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_saturation();
    int k;
    can_tx[0] = 1'b0;
    for (int r = 0; r < 300; r++) begin
      node_en[0] = 1'b1;
      k = 0;
      while (fault_pulse[0] !== 1'b1 && k < 20) begin tick(); k++; end
      if (k >= 20) begin
        n_tests++; n_fail++; $display("FAIL sat_timeout: round %0d got no pulse want pulse", r);
        break;
      end
      node_en[0] = 1'b0;
      tick();
    end
    n_tests++;
    if (fault_cnt[0 +: CW] !== 8'd255) begin
      n_fail++; $display("FAIL sat_count: got %0d want 255", fault_cnt[0 +: CW]);
    end
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL sat_model: got %h want %h", dut_vec, exp_vec());
    end
    // Reset with node 3 isolated and node 0 part-way through a dominant run.
    node_en = '1;
    can_tx = 4'b0111;
    repeat (6) tick();
    can_tx = 4'b0110;
    repeat (6) tick();
    n_tests++;
    if (isolated !== 4'b1000) begin
      n_fail++; $display("FAIL rst_precond: got iso %b want 1000", isolated);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({can_rx, isolated, fault_pulse} !== 12'hF00 || fault_cnt !== '0) begin
      n_fail++; $display("FAIL rst_midrun: got %h want f00 cnt 0", dut_vec);
    end
    rst = 1'b0;
    can_tx = '1;
    repeat (3) tick();
  endtask

  task automatic test_random();
    int burst[N];
    for (int i = 0; i < N; i++) burst[i] = 0;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (burst[i] == 0 && $urandom_range(0, 19) == 0) burst[i] = $urandom_range(1, 14);
        can_tx[i] = (burst[i] == 0);
        if (burst[i] > 0) burst[i]--;
      end
      if ($urandom_range(0, 149) == 0) node_en[$urandom_range(0, N-1)] ^= 1'b1;
      rst = ($urandom_range(0, 999) == 0);
      tick();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random c=%0d: got %h want %h", c, dut_vec, exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; can_tx = '1; node_en = '1;
    test_reset();
    test_latency();
    test_babble();
    test_recovery_wait();
    test_simultaneous();
    test_disable();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/can_bus_guard.md
Name: can_bus_guard

Overview:
- Clocked arbiter and guard for the on-chip wired-AND CAN bridge shared by N CAN controllers.
- Each node's TX is synchronised, checked for a stuck-dominant ("babbling") condition and gated before the AND.
- A faulty or software-disabled node is isolated so the remaining nodes keep communicating.
- Sits between the CAN controller TX/RX pins and the bus; replaces the purely combinational bridge.

Parameters:
- N_NODES, 4, number of attached CAN nodes (2..8).
- DOM_LIMIT, 1000, consecutive dominant clk samples from one node that trigger isolation (greater than 17 bit times at the system bit rate).
- REC_LIMIT, 600, consecutive recessive clk samples from an isolated node required before re-admission (11 bit times or more).
- CNT_W, 8, width of each per-node saturating fault counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- can_tx  in  N_NODES  raw TX per node; 0 = dominant, 1 = recessive.
- can_rx  out  N_NODES  bus level to each node; all bits identical.
- node_en  in  N_NODES  software enable mask; 0 forces that node recessive.
- isolated  out  N_NODES  1 while a node is in state ISOLATED.
- fault_pulse  out  N_NODES  one-cycle pulse on each ACTIVE->ISOLATED transition.
- fault_cnt  out  N_NODES*CNT_W  packed saturating isolation counts; node i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset values (rst high at a clk edge):
  - sync flops = 1, can_rx = all 1, isolated = 0, fault_pulse = 0, fault_cnt = 0.
  - all node states ACTIVE; dominant and recessive counters = 0.
- Input path:
  - Each can_tx bit passes a 2-flop synchroniser, giving tx_s.
  - gated_i = tx_s_i OR NOT(node_en_i) OR (state_i == ISOLATED).
  - can_rx is registered: every bit = AND of all gated_i.
  - Total latency from can_tx to can_rx is 3 clk edges.
- State ACTIVE, with node_en = 1:
  - dom_cnt increments while tx_s = 0 and clears to 0 when tx_s = 1.
  - The sample that brings dom_cnt to DOM_LIMIT moves the node to ISOLATED at that edge.
  - On that same edge: fault_pulse asserts for exactly one cycle, fault_cnt increments (saturates at 2^CNT_W-1), and dom_cnt clears.
- State ISOLATED:
  - The node contributes recessive from the first cycle of ISOLATED onward.
  - rec_cnt increments while tx_s = 1 and clears when tx_s = 0; it saturates at REC_LIMIT.
  - When rec_cnt == REC_LIMIT and the registered can_rx is recessive, the node moves to ACTIVE at the next edge; both counters clear.
  - If the bus is dominant at that point, the node waits in ISOLATED, holding its rec_cnt.
- node_en = 0 (any state):
  - The node is forced to ACTIVE with counters cleared.
  - It contributes recessive; isolated = 0 and fault_pulse is not generated.
  - fault_cnt is retained. Re-enabling resumes normal checking from count 0.
- Simultaneous events:
  - Nodes are independent; several nodes may isolate or recover on the same edge.
  - If every node is isolated or disabled, can_rx = all 1.
- rst mid-operation:
  - All state returns to reset values at the next edge, including isolated nodes (re-admitted immediately) and fault_cnt.
- Counter width: dom_cnt and rec_cnt are each $clog2(max(DOM_LIMIT, REC_LIMIT)+1) bits and never wrap.

Decomposition:
- Shared package can_bridge_pkg:
  - node-state enum {ST_ACTIVE, ST_ISOLATED};
  - constants CAN_DOMINANT = 1'b0 and CAN_RECESSIVE = 1'b1.
- Sub-module can_node_guard, instantiated N_NODES times. Each instance owns one node's synchroniser, counters, FSM, fault counter, fault_pulse and gated output.
- The top module performs the AND reduction and registers can_rx.

Test Plan:
- Common bench setup: N_NODES=4, DOM_LIMIT=8, REC_LIMIT=16, CNT_W=8.
- Reset release, all TX = 1; drive node 0 TX = 0 for 3 cycles -> can_rx = 4'b0000 exactly 3 edges after the first dominant sample, back to 4'b1111 3 edges after TX returns to 1; no fault_pulse.
- Hold node 2 TX = 0 permanently -> fault_pulse[2] for one cycle on the 8th dominant sample; isolated[2] = 1; can_rx returns to 1 within 2 cycles; fault_cnt[2] = 1.
- Isolated node 2: TX = 1 for 16 cycles while node 1 holds the bus dominant -> node 2 stays isolated; release node 1 -> node 2 re-admitted on the first recessive can_rx cycle.
- Nodes 0 and 3 stuck dominant on the same cycle -> both fault_pulse bits fire on the same edge; isolated = 4'b1001.
- node_en[1] = 0 while node 1 TX = 0 -> can_rx stays 1, no isolation. Then node_en[1] = 1 -> isolation after 8 more dominant samples.
- Force isolation 300 times on node 0 -> fault_cnt[0] saturates at 255. Assert rst mid-dominant-run -> all outputs return to reset values.
